// File: rtl/mux_4to1.sv
// ============================================================================
// Module   : mux_4to1
// Brief    : Registered 4-to-1 lane selector with valid qualifier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4to1 #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN*DATA_W-1:0]   In,
    input  logic [1:0]                 Sel,
    input  logic                       in_valid,
    output logic [DATA_W-1:0]          Out,
    output logic                       out_valid
);

    logic [DATA_W-1:0] w_lane [NUM_IN];
    logic [DATA_W-1:0] w_sel_lane;

    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;
    logic              valid_d;
    logic              valid_q;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        assign w_lane[k] = In[k*DATA_W +: DATA_W];
    end

    assign w_sel_lane = w_lane[Sel];

    // Out holds its last capture across idle cycles; only the qualifier drops.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = w_sel_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign Out       = out_q;
    assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_4to1.sv
// ============================================================================
// Module   : tb_mux_4to1
// Brief    : Self-checking bench for mux_4to1 with a shift-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4to1;

    logic         clk;
    logic         rst_n;
    logic [127:0] In;
    logic [1:0]   Sel;
    logic         in_valid;
    logic [31:0]  Out;
    logic         out_valid;

    int n_pass;
    int n_total;

    logic [31:0] m_out;
    logic        m_valid;

    mux_4to1 #(.DATA_W(32), .NUM_IN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In        (In),
        .Sel       (Sel),
        .in_valid  (in_valid),
        .Out       (Out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input logic [127:0] bus, input logic [1:0] s);
        logic [127:0] sh;
        sh = bus >> (32 * int'(s));
        return sh[31:0];
    endfunction

    // Reference model: selected word is the bus shifted down by 32*Sel.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= 32'h0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) m_out <= pick(In, Sel);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_out", Out, m_out);
        chk("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
    end

    task automatic drive(input logic [127:0] d, input logic [1:0] s, input logic v);
        In       = d;
        Sel      = s;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        logic [127:0] sweep;
        logic [127:0] w;
        logic [31:0]  exp;
        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b1;
        In       = {$urandom, $urandom, $urandom, $urandom};
        Sel      = 2'($urandom_range(0, 3));
        in_valid = 1'b1;

        // Asynchronous reset, checked before the first clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_out", Out, 32'h0);
        chk("reset_valid", {31'b0, out_valid}, 32'h0);

        @(posedge clk); @(posedge clk);
        chk("reset_hold_out", Out, 32'h0);
        #2;
        rst_n = 1'b1;
        drive(128'h1234, 2'd0, 1'b0);
        chk("post_reset_out", Out, 32'h0);
        chk("post_reset_valid", {31'b0, out_valid}, 32'h0);

        // Single-bit lane.
        drive(128'h0000_0000_0000_0001_0000_0000_0000_0000, 2'd2, 1'b1);
        chk("bit64_sel2", Out, 32'h0000_0001);
        chk("bit64_valid", {31'b0, out_valid}, 32'h1);
        drive(128'h0000_0000_0000_0001_0000_0000_0000_0000, 2'd1, 1'b1);
        chk("bit64_sel1", Out, 32'h0);
        drive(128'h0000_0000_0000_0001_0000_0000_0000_0000, 2'd3, 1'b1);
        chk("bit64_sel3", Out, 32'h0);

        // Lane sweep, back to back.
        sweep = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
        drive(sweep, 2'd0, 1'b1);
        chk("sweep0", Out, 32'hAAAA_AAAA);
        drive(sweep, 2'd1, 1'b1);
        chk("sweep1", Out, 32'hBBBB_BBBB);
        drive(sweep, 2'd2, 1'b1);
        chk("sweep2", Out, 32'hCCCC_CCCC);
        drive(sweep, 2'd3, 1'b1);
        chk("sweep3", Out, 32'hDDDD_DDDD);
        chk("sweep_valid", {31'b0, out_valid}, 32'h1);

        // Hold while idle with changing inputs.
        drive(128'h5555_6666_7777_8888_9999_0000_1111_2222, 2'd0, 1'b0);
        chk("hold_out_a", Out, 32'hDDDD_DDDD);
        chk("hold_valid_a", {31'b0, out_valid}, 32'h0);
        #2 Sel = 2'd1; In = ~In;
        drive(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 2'd2, 1'b0);
        chk("hold_out_b", Out, 32'hDDDD_DDDD);
        chk("hold_valid_b", {31'b0, out_valid}, 32'h0);

        // Walking one across all bits for each select.
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 128; b++) begin
                w = 128'h1 << b;
                drive(w, 2'(s), 1'b1);
                exp = (b / 32 == s) ? (32'h1 << (b % 32)) : 32'h0;
                chk("walk", Out, exp);
            end
        end

        // Short reset pulse between edges.
        drive(sweep, 2'd1, 1'b1);
        chk("pre_mid_reset", Out, 32'hBBBB_BBBB);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_out", Out, 32'h0);
        chk("mid_reset_valid", {31'b0, out_valid}, 32'h0);
        #1 rst_n = 1'b1;
        drive(sweep, 2'd2, 1'b1);
        chk("resume_out", Out, 32'hCCCC_CCCC);
        chk("resume_valid", {31'b0, out_valid}, 32'h1);
        drive(sweep, 2'd0, 1'b0);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
